icache: RTL
===========

Name: icache

Overview:
- Direct-mapped instruction cache; the responder for the fetch unit's rn/addr read-request interface.
- Returns one 32-bit instruction per accepted request, with a single-cycle Read_ready pulse.
- On a miss, refills a whole line from the memory controller over a word-level req/valid interface, then responds.
- Sits between the fetch unit and the memory controller/arbiter.

Parameters:
- LINES, 64, number of cache lines (power of 2).
- LINE_WORDS, 4, 32-bit words per line (power of 2, ≥2).
- ADDR_W, 18, significant address bits; addr[31:ADDR_W] ignored.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; when low, all state and outputs freeze
- clr  in  1  flow-control flush; drops the pending request, keeps cache contents
- rn  in  1  fetch read request; held with addr stable until Read_ready
- addr  in  32  fetch byte address, word aligned ([1:0] ignored)
- Inst  out  32  returned instruction
- Read_ready  out  1  one-cycle pulse: Inst valid for the accepted request
- mem_req  out  1  word read request to the memory controller
- mem_addr  out  32  word address of the current refill beat
- mem_valid  in  1  one-cycle pulse: mem_data answers the current mem_addr
- mem_data  in  32  returned memory word

Behaviour:
- Address split (defaults):
  - offset = addr[3:2]
  - index = addr[9:4]
  - tag = addr[17:10]
  - General form: offset width log2(LINE_WORDS), index width log2(LINES), tag = remaining bits up to ADDR_W.
- Storage: data[LINES*LINE_WORDS] x32, tag[LINES], valid[LINES].
- Reset values (applied on the rst edge, regardless of rdy):
  - all valid cleared
  - state=IDLE
  - Read_ready=0, Inst=0
  - mem_req=0, mem_addr=0
  - beat counter=0, drop flag=0
- States: IDLE, REFILL.
- IDLE: at a posedge with rn=1, Read_ready=0 and clr=0, capture addr.
  - Hit (valid && tag match): Read_ready<=1 and Inst<=word on the same edge. Response appears the cycle after the request is sampled.
  - Miss: go to REFILL; mem_req<=1; mem_addr<=line base ({tag,index,0..0,2'b00}); beat counter<=0; drop<=0.
- Mandatory bubble: no request is accepted on an edge where Read_ready is already 1.
  - Prevents re-serving a stale addr, since the requester updates addr on that same edge.
  - Peak hit throughput: 1 per 2 cycles.
- Read_ready is deasserted on every edge where it is not set.
- REFILL:
  - On each mem_valid edge: write mem_data into data[index][beat] and increment the beat counter.
  - Non-last beat: mem_addr<=mem_addr+4; mem_req stays 1.
  - Last beat (beat==LINE_WORDS-1):
    - mem_req<=0; tag[index]<=tag; valid[index]<=1; state<=IDLE.
    - If drop=0: Read_ready<=1 and Inst<=requested word. Use mem_data directly when the requested offset is the last beat.
  - Refill order is always word 0 to LINE_WORDS-1 (no critical-word-first).
  - mem_addr stays stable while waiting for mem_valid.
- clr:
  - In IDLE: Read_ready<=0; no capture on that edge.
  - In REFILL: drop<=1. The refill runs to completion (memory beats are never aborted), the line becomes valid, and no Read_ready is issued.
  - clr has priority over capture.
- rdy=0: no state, array or output changes. mem_valid is ignored (the memory controller shares rdy). rst overrides rdy.
- rst mid-refill: mem_req=0 after the edge, all lines invalid, partial line discarded.
- mem_valid in IDLE: ignored.
- Index/tag/offset arithmetic is unsigned; mem_addr increment stays within the line (no carry into index).

Decomposition:
- constants.v gains:
  - `ICACHE_LINES, `ICACHE_LINE_WORDS
  - state encodings `IC_IDLE, `IC_REFILL
  - reuses `Data_Bus, `True, `False
- One sub-module, icache_array: data/tag/valid storage.
  - Read: combinational by index/offset.
  - Write: word write, tag+valid write, global valid clear.
- FSM, refill counter and handshake live in icache.

Test Plan:
1. Reset, then rn=1 addr=0x0000 → mem_req=1, mem_addr 0x0/0x4/0x8/0xC. Return 0xA0,0xA1,0xA2,0xA3 → Read_ready pulses one cycle after the 4th mem_valid, Inst=0xA0, mem_req=0.
2. Then addr=0x0008 → Read_ready in the next cycle, Inst=0xA2, mem_req never rises. Hold rn with the addr change on Read_ready → exactly one bubble cycle, no duplicate response.
3. Conflict: addr=0x0400 (index 0, tag 1) → refill 0x400–0x40C. Then addr=0x0000 → misses again and re-refills.
4. clr pulsed after the 2nd refill beat for 0x0040 → no Read_ready; remaining beats 0x48,0x4C are still fetched. Later addr=0x0044 → hit, no mem_req.
5. Hold rdy=0 for 3 cycles mid-refill with mem_valid pulsing → mem_addr, beat count and outputs frozen. Resume → completes correctly.
6. rst during refill of 0x0100 → mem_req=0 next cycle. Request 0x0000 (cached earlier) → misses.

Source files
------------

// File: rtl/icache_pkg.sv
// icache_pkg: shared constants and state encoding for the instruction cache.
// Exports default geometry, data bus width and the ic_state_e FSM type.
package icache_pkg;

  localparam int unsigned ICACHE_LINES      = 64;
  localparam int unsigned ICACHE_LINE_WORDS = 4;
  localparam int unsigned ICACHE_ADDR_W     = 18;
  localparam int unsigned DATA_BUS          = 32;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic {
    IC_IDLE   = 1'b0,
    IC_REFILL = 1'b1
  } ic_state_e;

endpackage

// File: rtl/icache_array.sv
// icache_array: data/tag/valid storage, combinational read by index/offset.
// Ports: rd_* read side, wr_* word write, tag_we_i tag+valid write, clr_all_i.
import icache_pkg::*;

module icache_array #(
  parameter int unsigned LINES      = ICACHE_LINES,
  parameter int unsigned LINE_WORDS = ICACHE_LINE_WORDS,
  parameter int unsigned TAG_W      = 8,
  localparam int unsigned IDX_W     = $clog2(LINES),
  localparam int unsigned OFF_W     = $clog2(LINE_WORDS)
) (
  input  logic                clk,
  input  logic                clr_all_i,
  input  logic [IDX_W-1:0]    rd_idx_i,
  input  logic [OFF_W-1:0]    rd_off_i,
  output logic [DATA_BUS-1:0] rd_data_o,
  output logic [TAG_W-1:0]    rd_tag_o,
  output logic                rd_valid_o,
  input  logic                wr_en_i,
  input  logic [IDX_W-1:0]    wr_idx_i,
  input  logic [OFF_W-1:0]    wr_off_i,
  input  logic [DATA_BUS-1:0] wr_data_i,
  input  logic                tag_we_i,
  input  logic [TAG_W-1:0]    tag_i
);

  logic [DATA_BUS-1:0] data_q [LINES*LINE_WORDS];
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [LINES-1:0]    valid_q;

  assign rd_data_o  = data_q[{rd_idx_i, rd_off_i}];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];

  always_ff @(posedge clk) begin
    if (wr_en_i)
      data_q[{wr_idx_i, wr_off_i}] <= wr_data_i;
    if (tag_we_i)
      tag_q[wr_idx_i] <= tag_i;
  end

  always_ff @(posedge clk) begin
    if (clr_all_i)
      valid_q <= '0;
    else if (tag_we_i)
      valid_q[wr_idx_i] <= TRUE;
  end

endmodule

// File: rtl/icache.sv
// icache: direct-mapped instruction cache between fetch unit and memory.
// Ports: rn/addr -> Inst/Read_ready fetch side; mem_req/mem_addr/mem_valid/mem_data refill side.
import icache_pkg::*;

module icache #(
  parameter int unsigned LINES      = ICACHE_LINES,
  parameter int unsigned LINE_WORDS = ICACHE_LINE_WORDS,
  parameter int unsigned ADDR_W     = ICACHE_ADDR_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clr,
  input  logic        rn,
  input  logic [31:0] addr,
  output logic [31:0] Inst,
  output logic        Read_ready,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_data
);

  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - OFF_W - 2;
  localparam int unsigned IDX_L = OFF_W + 2;
  localparam int unsigned TAG_L = IDX_W + OFF_W + 2;
  localparam logic [OFF_W-1:0] LAST = OFF_W'(LINE_WORDS - 1);

  ic_state_e          state_q;
  logic               ready_q;
  logic [31:0]        inst_q;
  logic               req_q;
  logic [31:0]        maddr_q;
  logic [OFF_W-1:0]   beat_q;
  logic               drop_q;
  logic [OFF_W-1:0]   roff_q;
  logic [IDX_W-1:0]   ridx_q;
  logic [TAG_W-1:0]   rtag_q;

  logic [OFF_W-1:0]   off_a;
  logic [IDX_W-1:0]   idx_a;
  logic [TAG_W-1:0]   tag_a;
  logic [IDX_W-1:0]   rd_idx;
  logic [OFF_W-1:0]   rd_off;
  logic [31:0]        rd_data;
  logic [TAG_W-1:0]   rd_tag;
  logic               rd_valid;
  logic               hit;
  logic               last;
  logic               beat_fire;
  logic [31:0]        resp_word;
  logic               unused_ok;

  assign off_a = addr[IDX_L-1:2];
  assign idx_a = addr[TAG_L-1:IDX_L];
  assign tag_a = addr[ADDR_W-1:TAG_L];
  assign unused_ok = ^{addr[31:ADDR_W], addr[1:0]};

  // IDLE looks up the live request; REFILL reads back the captured word.
  assign rd_idx = (state_q == IC_IDLE) ? idx_a : ridx_q;
  assign rd_off = (state_q == IC_IDLE) ? off_a : roff_q;

  assign hit  = rd_valid && (rd_tag == tag_a);
  assign last = (beat_q == LAST);

  assign beat_fire = rdy && !rst && mem_valid &&
                     (state_q == IC_REFILL);

  // The last beat is not in the array yet on the edge it arrives.
  assign resp_word = (roff_q == LAST) ? mem_data : rd_data;

  icache_array #(
    .LINES      (LINES),
    .LINE_WORDS (LINE_WORDS),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk        (clk),
    .clr_all_i  (rst),
    .rd_idx_i   (rd_idx),
    .rd_off_i   (rd_off),
    .rd_data_o  (rd_data),
    .rd_tag_o   (rd_tag),
    .rd_valid_o (rd_valid),
    .wr_en_i    (beat_fire),
    .wr_idx_i   (ridx_q),
    .wr_off_i   (beat_q),
    .wr_data_i  (mem_data),
    .tag_we_i   (beat_fire && last),
    .tag_i      (rtag_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IC_IDLE;
      ready_q <= FALSE;
      inst_q  <= '0;
      req_q   <= FALSE;
      maddr_q <= '0;
      beat_q  <= '0;
      drop_q  <= FALSE;
      roff_q  <= '0;
      ridx_q  <= '0;
      rtag_q  <= '0;
    end else if (rdy) begin
      ready_q <= FALSE;
      unique case (state_q)
        IC_IDLE: begin
          // No capture while Read_ready is up: addr is still stale.
          if (!clr && rn && !ready_q) begin
            roff_q <= off_a;
            ridx_q <= idx_a;
            rtag_q <= tag_a;
            if (hit) begin
              ready_q <= TRUE;
              inst_q  <= rd_data;
            end else begin
              state_q <= IC_REFILL;
              req_q   <= TRUE;
              maddr_q <= {{(32-ADDR_W){1'b0}}, tag_a, idx_a,
                          {OFF_W{1'b0}}, 2'b00};
              beat_q  <= '0;
              drop_q  <= FALSE;
            end
          end
        end
        IC_REFILL: begin
          if (clr)
            drop_q <= TRUE;
          if (mem_valid) begin
            beat_q <= OFF_W'(beat_q + 1'b1);
            if (last) begin
              req_q   <= FALSE;
              state_q <= IC_IDLE;
              if (!drop_q && !clr) begin
                ready_q <= TRUE;
                inst_q  <= resp_word;
              end
            end else begin
              // Offset wraps inside the line, never into the index.
              maddr_q <= {maddr_q[31:IDX_L],
                          OFF_W'(beat_q + 1'b1), 2'b00};
            end
          end
        end
      endcase
    end
  end

  assign Inst       = inst_q;
  assign Read_ready = ready_q;
  assign mem_req    = req_q;
  assign mem_addr   = maddr_q;

endmodule
